// File: rtl/hbm_burst_reader_if.sv
`default_nettype none
// hbm_burst_reader_if: command, AXI4 read-channel and output-stream signals of hbm_burst_reader.
// The master modport is the reader's view; slave is the view of everything around it.
interface hbm_burst_reader_if #(
  parameter int AXI_AW = 64,
  parameter int DATA_W = 512
);
  logic              cmd_valid;
  logic              cmd_ready;
  logic [AXI_AW-1:0] cmd_addr;
  logic [15:0]       cmd_beats;

  logic [AXI_AW-1:0] axi_araddr;
  logic [7:0]        axi_arlen;
  logic              axi_arvalid;
  logic              axi_arready;
  logic [DATA_W-1:0] axi_rdata;
  logic              axi_rvalid;
  logic              axi_rlast;
  logic              axi_rready;

  logic [DATA_W-1:0] m_tdata;
  logic              m_tvalid;
  logic              m_tready;
  logic              m_tlast;

  modport master (
    input  cmd_valid, cmd_addr, cmd_beats,
    output cmd_ready,
    output axi_araddr, axi_arlen, axi_arvalid, axi_rready,
    input  axi_arready, axi_rdata, axi_rvalid, axi_rlast,
    output m_tdata, m_tvalid, m_tlast,
    input  m_tready
  );

  modport slave (
    output cmd_valid, cmd_addr, cmd_beats,
    input  cmd_ready,
    input  axi_araddr, axi_arlen, axi_arvalid, axi_rready,
    output axi_arready, axi_rdata, axi_rvalid, axi_rlast,
    input  m_tdata, m_tvalid, m_tlast,
    output m_tready
  );
endinterface
`default_nettype wire

// File: rtl/hbm_burst_reader.sv
`default_nettype none
// hbm_burst_reader: splits {addr, beats} commands into single-outstanding AXI4 read bursts and streams the data out.
// Define HBM_RD_4K_SPLIT_EN to keep every burst inside one 4 KB page.
module hbm_burst_reader #(
  parameter int AXI_AW     = 64,
  parameter int DATA_W     = 512,
  parameter int MAX_BURST  = 16,
  parameter int FIFO_DEPTH = 32
) (
  input  wire logic          ap_clk,
  input  wire logic          rst,
  hbm_burst_reader_if.master bus,
  output logic               busy,
  output logic               err_rlast
);

  localparam int BEAT_BYTES = DATA_W / 8;
  localparam int PW         = $clog2(FIFO_DEPTH);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ADDR = 2'd1,
    DATA = 2'd2
  } state_t;

  state_t            r_state;
  logic [AXI_AW-1:0] r_addr;
  logic [AXI_AW-1:0] r_araddr;
  logic [15:0]       r_remaining;
  logic [8:0]        r_len;
  logic [8:0]        r_beat_cnt;
  logic [7:0]        r_arlen;
  logic              r_arvalid;
  logic              r_err_rlast;

  logic [DATA_W:0]   r_mem [FIFO_DEPTH];
  logic [PW-1:0]     r_wr_ptr;
  logic [PW-1:0]     r_rd_ptr;
  logic [PW:0]       r_count;

  logic [AXI_AW-1:0] w_next_addr;
  logic [15:0]       w_next_rem;
  logic [8:0]        w_first_len;
  logic [8:0]        w_next_len;
  logic              w_last_beat;
  logic              w_entry_last;
  logic              w_rready;
  logic              w_push;
  logic              w_pop;
  logic              w_empty;

  // Result never exceeds MAX_BURST (<= 256), so 9 bits always hold it.
  function automatic logic [8:0] cap9(input logic [15:0] x, input logic [15:0] lim);
    return 9'((x < lim) ? x : lim);
  endfunction

`ifdef HBM_RD_4K_SPLIT_EN
  function automatic logic [15:0] page_beats(input logic [11:0] off);
    logic [12:0] room;
    room = 13'd4096 - {1'b0, off};
    return 16'(room / 13'(BEAT_BYTES));
  endfunction
`endif

  assign w_next_addr = r_addr + AXI_AW'(r_len) * AXI_AW'(BEAT_BYTES);
  assign w_next_rem  = r_remaining - 16'(r_len);

  always_comb begin
    w_first_len = cap9(bus.cmd_beats, 16'(MAX_BURST));
    w_next_len  = cap9(w_next_rem, 16'(MAX_BURST));
`ifdef HBM_RD_4K_SPLIT_EN
    w_first_len = cap9(16'(w_first_len), page_beats(bus.cmd_addr[11:0]));
    w_next_len  = cap9(16'(w_next_len), page_beats(w_next_addr[11:0]));
`endif
  end

  assign w_last_beat  = (r_beat_cnt == r_len - 9'd1);
  assign w_entry_last = w_last_beat && (w_next_rem == 16'd0);

  // Two free slots keep room for one beat from a source that sees rready a cycle late.
  assign w_rready = (r_state == DATA) && (r_count <= (PW+1)'(FIFO_DEPTH - 2));
  assign w_push   = w_rready && bus.axi_rvalid;
  assign w_empty  = (r_count == '0);
  assign w_pop    = !w_empty && bus.m_tready;

  always_ff @(posedge ap_clk) begin
    if (rst) begin
      r_state     <= IDLE;
      r_addr      <= '0;
      r_araddr    <= '0;
      r_remaining <= '0;
      r_len       <= '0;
      r_beat_cnt  <= '0;
      r_arlen     <= '0;
      r_arvalid   <= 1'b0;
      r_err_rlast <= 1'b0;
    end else begin
      case (r_state)
        IDLE: begin
          if (bus.cmd_valid && bus.cmd_beats != 16'd0) begin
            r_addr      <= bus.cmd_addr;
            r_remaining <= bus.cmd_beats;
            r_len       <= w_first_len;
            r_araddr    <= bus.cmd_addr;
            r_arlen     <= 8'(w_first_len - 9'd1);
            r_arvalid   <= 1'b1;
            r_err_rlast <= 1'b0;
            r_state     <= ADDR;
          end
        end
        ADDR: begin
          if (bus.axi_arready) begin
            r_arvalid  <= 1'b0;
            r_beat_cnt <= '0;
            r_state    <= DATA;
          end
        end
        DATA: begin
          if (w_push) begin
            r_beat_cnt <= r_beat_cnt + 9'd1;
            if (bus.axi_rlast != w_last_beat) r_err_rlast <= 1'b1;
            // The counted beat, not rlast, closes the burst.
            if (w_last_beat) begin
              r_addr      <= w_next_addr;
              r_remaining <= w_next_rem;
              if (w_next_rem != 16'd0) begin
                r_len     <= w_next_len;
                r_araddr  <= w_next_addr;
                r_arlen   <= 8'(w_next_len - 9'd1);
                r_arvalid <= 1'b1;
                r_state   <= ADDR;
              end else begin
                r_state   <= IDLE;
              end
            end
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  always_ff @(posedge ap_clk) begin
    if (w_push) r_mem[r_wr_ptr] <= {w_entry_last, bus.axi_rdata};
  end

  always_ff @(posedge ap_clk) begin
    if (rst) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + PW'(1);
      if (w_pop)  r_rd_ptr <= r_rd_ptr + PW'(1);
      r_count <= r_count + (PW+1)'(w_push) - (PW+1)'(w_pop);
    end
  end

  assign bus.cmd_ready   = (r_state == IDLE) && !rst;
  assign bus.axi_araddr  = r_araddr;
  assign bus.axi_arlen   = r_arlen;
  assign bus.axi_arvalid = r_arvalid;
  assign bus.axi_rready  = w_rready;
  assign bus.m_tvalid    = !w_empty;
  assign {bus.m_tlast, bus.m_tdata} = w_empty ? '0 : r_mem[r_rd_ptr];
  assign busy            = (r_state != IDLE) || !w_empty;
  assign err_rlast       = r_err_rlast;

endmodule
`default_nettype wire

// File: tb/tb_hbm_burst_reader.sv
`default_nettype none
// tb_hbm_burst_reader: randomized AXI slave and stream sink checked every cycle against a transaction-level model.
module tb_hbm_burst_reader;
  localparam int AW = 64;
  localparam int DW = 512;
  localparam int MB = 16;
  localparam int FD = 32;
  localparam int BB = DW / 8;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic busy;
  logic err_rlast;

  hbm_burst_reader_if #(.AXI_AW(AW), .DATA_W(DW)) bus ();

  hbm_burst_reader #(.AXI_AW(AW), .DATA_W(DW), .MAX_BURST(MB), .FIFO_DEPTH(FD)) dut (
    .ap_clk    (clk),
    .rst       (rst),
    .bus       (bus),
    .busy      (busy),
    .err_rlast (err_rlast)
  );

  always #5 clk = ~clk;

  typedef struct packed { logic [63:0] addr; logic [7:0] len; } ar_t;
  typedef struct packed { logic last; logic [DW-1:0] data; } beat_t;

  int total = 0;
  int bad = 0;
  ar_t   exp_ar[$];
  ar_t   ar_log[$];
  beat_t exp_st[$];
  int occ = 0, btr = 0, max_occ = 0, pop_cnt = 0, last_cnt = 0, last_pos = 0;
  int sl_len = 0, sl_idx = 0, stall = 0;
  bit sl_busy = 0, exp_err = 0, inject = 0, push = 0, pop = 0;
  logic [63:0] sl_addr = '0;
  beat_t e;
  ar_t   ar_tmp;

  function automatic logic [DW-1:0] pat(input logic [63:0] a);
    return {4{a, ~a}};
  endfunction

  task automatic chk(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", name, act, exp);
    end
  endtask

  // Expected bursts and stream beats for one command, from the splitting rules.
  function automatic void plan(input logic [63:0] a0, input int beats);
    logic [63:0] a;
    int rem, l;
    a = a0;
    rem = beats;
    for (int k = 0; k < beats; k++) exp_st.push_back({k == beats - 1, pat(a0 + 64'(k * BB))});
    while (rem > 0) begin
      l = (rem < MB) ? rem : MB;
`ifdef HBM_RD_4K_SPLIT_EN
      if ((4096 - int'(a[11:0])) / BB < l) l = (4096 - int'(a[11:0])) / BB;
`endif
      exp_ar.push_back({a, 8'(l - 1)});
      a += 64'(l * BB);
      rem -= l;
    end
  endfunction

  // Environment: AXI slave, stream sink and the per-cycle compare.
  initial begin
    bus.axi_arready = 1'b0;
    bus.axi_rvalid  = 1'b0;
    bus.axi_rdata   = '0;
    bus.axi_rlast   = 1'b0;
    bus.m_tready    = 1'b0;
    forever begin
      @(negedge clk);
      if (rst) begin
        chk("cmd_ready_in_rst", bus.cmd_ready, 0);
        occ = 0; btr = 0; sl_busy = 0; exp_err = 0; push = 0; pop = 0;
        exp_ar.delete();
        exp_st.delete();
      end else begin
        chk("cmd_ready", bus.cmd_ready, btr == 0);
        chk("busy", busy, btr != 0 || occ != 0);
        chk("m_tvalid", bus.m_tvalid, occ != 0);
        chk("arvalid", bus.axi_arvalid, btr != 0 && !sl_busy);
        chk("rready", bus.axi_rready, sl_busy && occ <= FD - 2);
        chk("err_rlast", err_rlast, exp_err);
        if (bus.axi_arvalid) begin
          if (exp_ar.size() == 0) chk("ar_unexpected", bus.axi_arvalid, 0);
          else begin
            chk("araddr", bus.axi_araddr, exp_ar[0].addr);
            chk("arlen", bus.axi_arlen, exp_ar[0].len);
          end
        end
        push = bus.axi_rvalid && bus.axi_rready;
        pop  = bus.m_tvalid && bus.m_tready;
        if (pop) begin
          pop_cnt++;
          if (exp_st.size() == 0) chk("pop_unexpected", bus.m_tvalid, 0);
          else begin
            e = exp_st.pop_front();
            chk("m_tdata", bus.m_tdata, e.data);
            chk("m_tlast", bus.m_tlast, e.last);
          end
          if (bus.m_tlast) begin
            last_cnt++;
            last_pos = pop_cnt;
          end
        end
        if (bus.axi_arvalid && bus.axi_arready) begin
          if (exp_ar.size() > 0) ar_tmp = exp_ar.pop_front();
          ar_log.push_back({bus.axi_araddr, bus.axi_arlen});
          sl_busy = 1;
          sl_addr = bus.axi_araddr;
          sl_len  = int'(bus.axi_arlen);
          sl_idx  = 0;
        end
        if (push) begin
          if (bus.axi_rlast != (sl_idx == sl_len)) exp_err = 1;
          sl_idx++;
          btr--;
          if (sl_idx > sl_len) sl_busy = 0;
        end
        occ = occ + int'(push) - int'(pop);
        if (occ > max_occ) max_occ = occ;
        if (bus.cmd_valid && bus.cmd_ready && bus.cmd_beats != 16'd0) begin
          plan(bus.cmd_addr, int'(bus.cmd_beats));
          btr = int'(bus.cmd_beats);
          exp_err = 0;
        end
      end
      @(posedge clk);
      #1;
      bus.axi_arready = 1'($urandom_range(0, 1));
      if (!sl_busy) bus.axi_rvalid = 1'b0;
      else if (!(bus.axi_rvalid && !push)) bus.axi_rvalid = ($urandom_range(0, 3) != 0);
      bus.axi_rdata = pat(sl_addr + 64'(sl_idx * BB));
      bus.axi_rlast = (sl_idx == sl_len) || (inject && sl_idx == 3);
      if (stall > 0) begin
        bus.m_tready = 1'b0;
        stall--;
      end else begin
        bus.m_tready = ($urandom_range(0, 3) != 0);
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic send_cmd(input logic [63:0] a, input int beats);
    bit got;
    got = 0;
    step();
    bus.cmd_addr  = a;
    bus.cmd_beats = 16'(beats);
    bus.cmd_valid = 1'b1;
    for (int i = 0; i < 3000; i++) begin
      @(negedge clk);
      if (bus.cmd_ready) begin
        got = 1;
        break;
      end
    end
    step();
    bus.cmd_valid = 1'b0;
    chk("cmd_accept_timeout", got, 1);
  endtask

  task automatic wait_done();
    bit done;
    done = 0;
    for (int i = 0; i < 5000; i++) begin
      @(negedge clk);
      if (btr == 0 && occ == 0) begin
        done = 1;
        break;
      end
    end
    @(negedge clk);
    chk("done_timeout", done, 1);
  endtask

  task automatic clear_logs();
    ar_log.delete();
    pop_cnt = 0; last_cnt = 0; last_pos = 0; max_occ = 0;
  endtask

  initial begin
    logic [63:0] a;
    int b;
    bus.cmd_valid = 1'b0;
    bus.cmd_addr  = '0;
    bus.cmd_beats = '0;
    repeat (4) @(posedge clk);
    #1;
    rst = 1'b0;
    @(negedge clk);
    chk("rst_cmd_ready", bus.cmd_ready, 1);
    chk("rst_arvalid", bus.axi_arvalid, 0);
    chk("rst_rready", bus.axi_rready, 0);
    chk("rst_m_tvalid", bus.m_tvalid, 0);
    chk("rst_busy", busy, 0);
    chk("rst_err_rlast", err_rlast, 0);

    clear_logs();
    send_cmd(64'h0, 40);
    wait_done();
    chk("t1_nbursts", ar_log.size(), 3);
    if (ar_log.size() == 3) begin
      chk("t1_ar0", ar_log[0], {64'h0, 8'd15});
      chk("t1_ar1", ar_log[1], {64'h400, 8'd15});
      chk("t1_ar2", ar_log[2], {64'h800, 8'd7});
    end
    chk("t1_beats", pop_cnt, 40);
    chk("t1_tlast_cnt", last_cnt, 1);
    chk("t1_tlast_pos", last_pos, 40);

    clear_logs();
    send_cmd(64'h3000, 1);
    wait_done();
    chk("t2_nbursts", ar_log.size(), 1);
    if (ar_log.size() == 1) chk("t2_arlen", ar_log[0].len, 0);
    chk("t2_beats", pop_cnt, 1);
    chk("t2_tlast_cnt", last_cnt, 1);
    chk("t2_busy", busy, 0);

    clear_logs();
    stall = 200;
    send_cmd(64'h8000, 64);
    wait_done();
    chk("t3_max_fill", max_occ, FD - 1);
    chk("t3_beats", pop_cnt, 64);
    chk("t3_tlast_pos", last_pos, 64);

    clear_logs();
    send_cmd(64'hF80, 8);
    wait_done();
`ifdef HBM_RD_4K_SPLIT_EN
    chk("t4_nbursts", ar_log.size(), 2);
    if (ar_log.size() == 2) begin
      chk("t4_ar0", ar_log[0], {64'hF80, 8'd1});
      chk("t4_ar1", ar_log[1], {64'h1000, 8'd5});
    end
`else
    chk("t4_nbursts", ar_log.size(), 1);
    if (ar_log.size() == 1) chk("t4_ar0", ar_log[0], {64'hF80, 8'd7});
`endif
    chk("t4_beats", pop_cnt, 8);

    clear_logs();
    inject = 1;
    send_cmd(64'h2_0000, 16);
    wait_done();
    inject = 0;
    chk("t5_err_set", err_rlast, 1);
    chk("t5_beats", pop_cnt, 16);
    send_cmd(64'h2_1000, 4);
    wait_done();
    chk("t5_err_cleared", err_rlast, 0);

    clear_logs();
    send_cmd(64'h40, 0);
    repeat (5) @(negedge clk);
    chk("null_nbursts", ar_log.size(), 0);
    chk("null_beats", pop_cnt, 0);
    chk("null_cmd_ready", bus.cmd_ready, 1);

    clear_logs();
    send_cmd(64'h1_0000, 64);
    for (int i = 0; i < 500 && !(sl_busy && sl_idx >= 3); i++) @(negedge clk);
    chk("t6_mid_burst", sl_busy, 1);
    step();
    rst = 1'b1;
    step();
    rst = 1'b0;
    @(negedge clk);
    chk("t6_arvalid", bus.axi_arvalid, 0);
    chk("t6_rready", bus.axi_rready, 0);
    chk("t6_m_tvalid", bus.m_tvalid, 0);
    chk("t6_busy", busy, 0);
    chk("t6_cmd_ready", bus.cmd_ready, 1);

    for (int n = 0; n < 30; n++) begin
      a = (64'($urandom_range(0, 3)) << 12) | (64'($urandom_range(0, 63)) << 6);
      b = ($urandom_range(0, 5) == 0) ? 0 : int'($urandom_range(1, 70));
      if ($urandom_range(0, 3) == 0) stall = int'($urandom_range(10, 60));
      send_cmd(a, b);
      if ($urandom_range(0, 1) == 1) wait_done();
    end
    wait_done();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
`default_nettype wire
